// File: rtl/powlib_busburst.sv
// powlib_busburst: turns one burst command into a stream of address/data beats on a powlib write port
module powlib_busburst #(
  parameter int B_AW = 2,
  parameter int B_DW = 4,
  parameter int L_W  = 4,
  parameter int ENF  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [B_AW-1:0] cmdbase,
  input  logic [B_DW-1:0] cmddata,
  input  logic [L_W-1:0]  cmdlen,
  input  logic            cmdinc,
  input  logic            cmdvld,
  output logic            cmdrdy,
  output logic [B_DW-1:0] wrdata,
  output logic [B_AW-1:0] wraddr,
  output logic            wrvld,
  input  logic            wrrdy,
  input  logic            wrnf,
  output logic            busy,
  output logic            done
);
  typedef enum logic [0:0] {IDLE, SEND} state_t;
  state_t            r_state, w_state;
  logic [L_W-1:0]    r_cnt, w_cnt, r_len, w_len;
  logic              r_inc, w_inc;
  logic [B_AW-1:0]   r_addr, w_addr;
  logic [B_DW-1:0]   r_data, w_data;
  logic              r_vld, w_vld, r_rdy, w_rdy, r_busy, w_busy, r_done, w_done;
  logic              w_go, w_xfer;
  assign w_go   = (ENF == 0) || !wrnf;
  assign w_xfer = r_vld && wrrdy;
  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_len   = r_len;
    w_inc   = r_inc;
    w_addr  = r_addr;
    w_data  = r_data;
    w_vld   = r_vld;
    w_rdy   = r_rdy;
    w_busy  = r_busy;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_rdy = 1'b1;
        if (cmdvld && r_rdy) begin
          w_state = SEND;
          w_cnt   = '0;
          w_len   = cmdlen;
          w_inc   = cmdinc;
          w_addr  = cmdbase;
          w_data  = cmddata;
          w_rdy   = 1'b0;
          w_busy  = 1'b1;
        end
      end
      default: begin
        if (!r_vld) w_vld = w_go;
        else if (w_xfer && r_cnt == r_len) begin
          w_state = IDLE;
          w_vld   = 1'b0;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_rdy   = 1'b1;
        end else if (w_xfer) begin
          w_cnt  = r_cnt + 1'b1;
          w_addr = r_addr + 1'b1;
          w_data = r_data + B_DW'(r_inc);
          w_vld  = w_go;
        end
      end
    endcase
  end
  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_inc   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_len   <= w_len;
      r_inc   <= w_inc;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_vld   <= w_vld;
      r_rdy   <= w_rdy;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end
  assign cmdrdy = r_rdy;
  assign wrdata = r_data;
  assign wraddr = r_addr;
  assign wrvld  = r_vld;
  assign busy   = r_busy;
  assign done   = r_done;
endmodule

// File: tb/tb_powlib_busburst.sv
// tb_powlib_busburst: directed checks of burst sequencing, stalls, nearly-full, back-to-back and reset
module tb_powlib_busburst;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmdbase;
  logic [3:0] cmddata;
  logic [3:0] cmdlen;
  logic       cmdinc, cmdvld, cmdrdy;
  logic [3:0] wrdata;
  logic [1:0] wraddr;
  logic       wrvld, wrrdy, wrnf, busy, done;
  int checks = 0;
  int errors = 0;
  powlib_busburst #(.B_AW(2), .B_DW(4), .L_W(4), .ENF(1)) dut (
    .clk(clk), .rst(rst), .cmdbase(cmdbase), .cmddata(cmddata), .cmdlen(cmdlen),
    .cmdinc(cmdinc), .cmdvld(cmdvld), .cmdrdy(cmdrdy), .wrdata(wrdata), .wraddr(wraddr),
    .wrvld(wrvld), .wrrdy(wrrdy), .wrnf(wrnf), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  // Compares {busy,cmdrdy,done,wrvld,wraddr,wrdata} against the expected vector.
  task automatic st(input string tag, input logic [9:0] e);
    logic [9:0] o;
    o = {busy, cmdrdy, done, wrvld, wraddr, wrdata};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed b/r/d/v=%b a=%0d d=%0d expected b/r/d/v=%b a=%0d d=%0d",
             tag, o[9:6], o[5:4], o[3:0], e[9:6], e[5:4], e[3:0]);
    end
  endtask
  task automatic cmd(input logic [1:0] b, input logic [3:0] d, input logic [3:0] l, input logic i);
    cmdbase = b; cmddata = d; cmdlen = l; cmdinc = i; cmdvld = 1'b1;
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b0; cmdbase = '0; cmddata = '0; cmdlen = '0; cmdinc = 1'b0; cmdvld = 1'b0;
    wrrdy = 1'b0; wrnf = 1'b0;
    cyc(); cyc();
    st("reset", {4'b0000, 2'd0, 4'd0});
    rst = 1'b1;
    cyc();
    st("release", {4'b0100, 2'd0, 4'd0});
    // Burst 1: base 1, data 5, three incrementing beats at full rate.
    cmd(2'd1, 4'd5, 4'd2, 1'b1); wrrdy = 1'b1;
    cyc(); st("t1 accept", {4'b1000, 2'd1, 4'd5}); cmdvld = 1'b0;
    cyc(); st("t1 beat0", {4'b1001, 2'd1, 4'd5});
    cyc(); st("t1 beat1", {4'b1001, 2'd2, 4'd6});
    cyc(); st("t1 beat2", {4'b1001, 2'd3, 4'd7});
    cyc(); st("t1 done", {4'b0110, 2'd3, 4'd7});
    cyc(); st("t1 idle", {4'b0100, 2'd3, 4'd7});
    // Burst 2: address wraps 3->0, constant data.
    cmd(2'd3, 4'd9, 4'd3, 1'b0);
    cyc(); st("t2 accept", {4'b1000, 2'd3, 4'd9}); cmdvld = 1'b0;
    cyc(); st("t2 beat0", {4'b1001, 2'd3, 4'd9});
    cyc(); st("t2 beat1", {4'b1001, 2'd0, 4'd9});
    cyc(); st("t2 beat2", {4'b1001, 2'd1, 4'd9});
    cyc(); st("t2 beat3", {4'b1001, 2'd2, 4'd9});
    cyc(); st("t2 done", {4'b0110, 2'd2, 4'd9});
    // Burst 3: ready high only one cycle in three; beats must hold while stalled.
    cmd(2'd0, 4'd2, 4'd3, 1'b1); wrrdy = 1'b0;
    cyc(); st("t3 accept", {4'b1000, 2'd0, 4'd2}); cmdvld = 1'b0;
    cyc();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 3; k++) begin
        wrrdy = (k == 2);
        st($sformatf("t3 beat%0d c%0d", b, k), {4'b1001, 2'(b), 4'(2 + b)});
        cyc();
      end
    st("t3 done", {4'b0110, 2'd3, 4'd5});
    // Burst 4: nearly-full holds off new beats but never retracts a valid one.
    wrnf = 1'b1; wrrdy = 1'b1; cmd(2'd2, 4'd0, 4'd1, 1'b1);
    cyc(); st("t4 accept", {4'b1000, 2'd2, 4'd0}); cmdvld = 1'b0;
    cyc(); st("t4 holdoff0", {4'b1000, 2'd2, 4'd0});
    cyc(); st("t4 holdoff1", {4'b1000, 2'd2, 4'd0});
    wrnf = 1'b0;
    cyc(); st("t4 beat0", {4'b1001, 2'd2, 4'd0});
    wrnf = 1'b1; wrrdy = 1'b0;
    cyc(); st("t4 beat0 kept", {4'b1001, 2'd2, 4'd0});
    wrrdy = 1'b1;
    cyc(); st("t4 nf gap0", {4'b1000, 2'd3, 4'd1});
    cyc(); st("t4 nf gap1", {4'b1000, 2'd3, 4'd1});
    wrnf = 1'b0;
    cyc(); st("t4 beat1", {4'b1001, 2'd3, 4'd1});
    cyc(); st("t4 done", {4'b0110, 2'd3, 4'd1});
    // Burst 5: two single-beat commands presented back to back.
    cmd(2'd1, 4'd4, 4'd0, 1'b1);
    cyc(); st("t5 acceptA", {4'b1000, 2'd1, 4'd4});
    cmd(2'd2, 4'd8, 4'd0, 1'b1);
    cyc(); st("t5 beatA busy", {4'b1001, 2'd1, 4'd4});
    cyc(); st("t5 doneA", {4'b0110, 2'd1, 4'd4});
    cyc(); st("t5 acceptB", {4'b1000, 2'd2, 4'd8}); cmdvld = 1'b0;
    cyc(); st("t5 beatB", {4'b1001, 2'd2, 4'd8});
    cyc(); st("t5 doneB", {4'b0110, 2'd2, 4'd8});
    // Burst 6: reset mid-burst, then a fresh burst restarts from its own base.
    cmd(2'd0, 4'd1, 4'd3, 1'b1);
    cyc(); st("t6 accept", {4'b1000, 2'd0, 4'd1}); cmdvld = 1'b0;
    cyc(); st("t6 beat0", {4'b1001, 2'd0, 4'd1});
    cyc(); st("t6 beat1", {4'b1001, 2'd1, 4'd2});
    #2 rst = 1'b0;
    #1 st("t6 async reset", {4'b0000, 2'd0, 4'd0});
    cyc(); st("t6 held reset", {4'b0000, 2'd0, 4'd0});
    rst = 1'b1;
    cyc(); st("t6 release", {4'b0100, 2'd0, 4'd0});
    cmd(2'd2, 4'd3, 4'd1, 1'b1);
    cyc(); st("t6 re-accept", {4'b1000, 2'd2, 4'd3}); cmdvld = 1'b0;
    cyc(); st("t6 new beat0", {4'b1001, 2'd2, 4'd3});
    cyc(); st("t6 new beat1", {4'b1001, 2'd3, 4'd4});
    cyc(); st("t6 new done", {4'b0110, 2'd3, 4'd4});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
